// File: rtl/fifo_pkg.sv
// Shared defaults and width helper for the lane FIFO.
// Pointer and count widths derive from clog2 of the depth.
package fifo_pkg;

   localparam int BW_DEF    = 4;
   localparam int WIDTH_DEF = 1;
   localparam int DEPTH_DEF = 64;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < v) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and flag control for the lane FIFO.
// Flags are computed from the next count so they move with it.
module fifo_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int depth    = DEPTH_DEF,
   parameter int af_level = depth - 4,
   localparam int aw      = clog2(depth),
   localparam int cw      = aw + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr,
   input  logic          rd,
   output logic          wen,
   output logic [aw-1:0] wptr,
   output logic [aw-1:0] rptr,
   output logic          full,
   output logic          empty,
   output logic          afull,
   output logic [cw-1:0] count,
   output logic          ovf,
   output logic          udf
);

   logic          ren;
   logic [cw-1:0] cnt_nxt;

   // Acceptance uses pre-edge flags; a read never frees room for a write.
   assign wen     = wr && !full;
   assign ren     = rd && !empty;
   assign cnt_nxt = count + cw'(wen) - cw'(ren);

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
         afull <= 1'b0;
         ovf   <= 1'b0;
         udf   <= 1'b0;
      end else begin
         if (wen) wptr <= wptr + aw'(1);
         if (ren) rptr <= rptr + aw'(1);
         count <= cnt_nxt;
         full  <= (cnt_nxt == cw'(depth));
         empty <= (cnt_nxt == '0);
         afull <= (cnt_nxt >= cw'(af_level));
         if (wr && full)  ovf <= 1'b1;
         if (rd && empty) udf <= 1'b1;
      end
   end

endmodule

// File: rtl/fifo_lanes.sv
// Multi-lane first-word-fall-through FIFO with shared pointers.
// Storage is unreset; out is only meaningful while not empty.
module fifo_lanes
   import fifo_pkg::*;
#(
   parameter int bw       = BW_DEF,
   parameter int width    = WIDTH_DEF,
   parameter int depth    = DEPTH_DEF,
   parameter int af_level = depth - 4,
   localparam int aw      = clog2(depth),
   localparam int cw      = aw + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [width*bw-1:0] in,
   input  logic               wr,
   input  logic               rd,
   output logic [width*bw-1:0] out,
   output logic               o_full,
   output logic               o_ready,
   output logic               o_empty,
   output logic               o_afull,
   output logic [cw-1:0]      o_count,
   output logic               o_ovf,
   output logic               o_udf
);

   logic [width*bw-1:0] mem [depth];
   logic                wen;
   logic [aw-1:0]       wptr;
   logic [aw-1:0]       rptr;

   fifo_ptr_ctrl #(
      .depth    (depth),
      .af_level (af_level)
   ) u_ctrl (
      .clk   (clk),
      .reset (reset),
      .wr    (wr),
      .rd    (rd),
      .wen   (wen),
      .wptr  (wptr),
      .rptr  (rptr),
      .full  (o_full),
      .empty (o_empty),
      .afull (o_afull),
      .count (o_count),
      .ovf   (o_ovf),
      .udf   (o_udf)
   );

   always_ff @(posedge clk) begin
      if (wen && !reset) mem[wptr] <= in;
   end

   assign out     = mem[rptr];
   assign o_ready = !o_full;

endmodule

// File: tb/tb_fifo_lanes.sv
// Directed bench for fifo_lanes: table of single-cycle vectors
// followed by a steady-state read/write wrap sequence.
module tb_fifo_lanes;

   localparam int BW = 4;
   localparam int WD = 2;
   localparam int DP = 8;
   localparam int AF = 6;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [7:0]    in = '0;
   logic          wr = 1'b0;
   logic          rd = 1'b0;
   logic [7:0]    out;
   logic          o_full, o_ready, o_empty, o_afull;
   logic [3:0]    o_count;
   logic          o_ovf, o_udf;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic       rst;
      logic       w;
      logic       r;
      logic [7:0] din;
      int         cnt;
      logic       f;
      logic       e;
      logic       af;
      logic       ov;
      logic       ud;
      logic       chk_out;
      logic [7:0] dout;
   } vec_t;

   vec_t vecs[$];
   logic [7:0] model[$];

   fifo_lanes #(
      .bw(BW), .width(WD), .depth(DP), .af_level(AF)
   ) dut (
      .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd),
      .out(out), .o_full(o_full), .o_ready(o_ready),
      .o_empty(o_empty), .o_afull(o_afull), .o_count(o_count),
      .o_ovf(o_ovf), .o_udf(o_udf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic rst, input logic w, input logic r, input logic [7:0] din,
      input int cnt, input logic f, input logic e, input logic af,
      input logic ov, input logic ud, input logic co, input logic [7:0] dout);
      vec_t v;
      v.rst = rst; v.w = w; v.r = r; v.din = din;
      v.cnt = cnt; v.f = f; v.e = e; v.af = af;
      v.ov = ov; v.ud = ud; v.chk_out = co; v.dout = dout;
      return v;
   endfunction

   task automatic step(input logic rst, input logic w, input logic r,
                       input logic [7:0] din);
      @(negedge clk);
      reset = rst; wr = w; rd = r; in = din;
      @(posedge clk);
      #1;
      reset = 1'b0; wr = 1'b0; rd = 1'b0;
   endtask

   initial begin
      // reset
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00));
      // fill 0x11..0x88
      for (int k = 1; k <= 8; k++)
         vecs.push_back(mk(0, 1, 0, 8'(k * 8'h11), k, k == 8, 0, k >= AF,
                           0, 0, 1, 8'h11));
      // overflow attempt
      vecs.push_back(mk(0, 1, 0, 8'h99, 8, 1, 0, 1, 1, 0, 1, 8'h11));
      // drain
      for (int i = 1; i <= 8; i++)
         vecs.push_back(mk(0, 0, 1, 8'h00, 8 - i, 0, i == 8, (8 - i) >= AF,
                           1, 0, i < 8, 8'((i + 1) * 8'h11)));
      // empty with wr&&rd
      vecs.push_back(mk(0, 1, 1, 8'h5A, 1, 0, 0, 0, 1, 1, 1, 8'h5A));
      vecs.push_back(mk(0, 1, 0, 8'h21, 2, 0, 0, 0, 1, 1, 1, 8'h5A));
      vecs.push_back(mk(0, 1, 0, 8'h32, 3, 0, 0, 0, 1, 1, 1, 8'h5A));
      vecs.push_back(mk(0, 1, 0, 8'h43, 4, 0, 0, 0, 1, 1, 1, 8'h5A));
      vecs.push_back(mk(0, 1, 0, 8'h54, 5, 0, 0, 0, 1, 1, 1, 8'h5A));
      // reset overrides write at count 5
      vecs.push_back(mk(1, 1, 0, 8'h77, 0, 0, 1, 0, 0, 0, 0, 8'h00));
      // lane isolation
      vecs.push_back(mk(0, 1, 0, 8'h0F, 1, 0, 0, 0, 0, 0, 1, 8'h0F));
      vecs.push_back(mk(0, 1, 1, 8'hF0, 1, 0, 0, 0, 0, 0, 1, 8'hF0));
      vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00));

      for (int n = 0; n < vecs.size(); n++) begin
         step(vecs[n].rst, vecs[n].w, vecs[n].r, vecs[n].din);
         chk($sformatf("v%0d count", n), int'(o_count), vecs[n].cnt);
         chk($sformatf("v%0d full", n), int'(o_full), int'(vecs[n].f));
         chk($sformatf("v%0d ready", n), int'(o_ready), int'(!vecs[n].f));
         chk($sformatf("v%0d empty", n), int'(o_empty), int'(vecs[n].e));
         chk($sformatf("v%0d afull", n), int'(o_afull), int'(vecs[n].af));
         chk($sformatf("v%0d ovf", n), int'(o_ovf), int'(vecs[n].ov));
         chk($sformatf("v%0d udf", n), int'(o_udf), int'(vecs[n].ud));
         if (vecs[n].chk_out)
            chk($sformatf("v%0d out", n), int'(out), int'(vecs[n].dout));
      end

      // half full, continuous wr&&rd with pointer wrap
      step(1, 0, 0, 8'h00);
      for (int k = 0; k < 4; k++) begin
         step(0, 1, 0, 8'(8'hA0 + k));
         model.push_back(8'(8'hA0 + k));
      end
      chk("half count", int'(o_count), 4);
      for (int c = 0; c < 20; c++) begin
         logic [7:0] d;
         d = 8'($urandom_range(0, 255));
         step(0, 1, 1, d);
         void'(model.pop_front());
         model.push_back(d);
         chk($sformatf("wrap%0d count", c), int'(o_count), 4);
         chk($sformatf("wrap%0d out", c), int'(out), int'(model[0]));
      end
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("tail%0d out", k), int'(out), int'(model[0]));
         void'(model.pop_front());
         step(0, 0, 1, 8'h00);
      end
      chk("tail empty", int'(o_empty), 1);
      chk("tail udf", int'(o_udf), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_lanes.md
FIFO_LANES -- requirements
Module: fifo_lanes

Interface
REQ-001 Parameter bw, default 4: bits per lane word.
REQ-002 Parameter width, default 1: number of lanes, all written and read together.
REQ-003 Parameter depth, default 64: entries per lane; power of two, at least 4.
REQ-004 Parameter af_level, default depth-4: o_afull threshold; range 1..depth-1.
REQ-005 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port in, input, width*bw: write data; lane k occupies bits [k*bw+bw-1 : k*bw].
REQ-008 Port wr, input, 1: write request.
REQ-009 Port rd, input, 1: read request; pops the head entry.
REQ-010 Port out, output, width*bw: head entry, lane layout as in; first-word-fall-through.
REQ-011 Port o_full, output, 1: occupancy equals depth.
REQ-012 Port o_ready, output, 1: exactly !o_full.
REQ-013 Port o_empty, output, 1: occupancy equals 0.
REQ-014 Port o_afull, output, 1: occupancy >= af_level.
REQ-015 Port o_count, output, clog2(depth)+1: current occupancy, 0..depth.
REQ-016 Port o_ovf, output, 1: sticky flag; write attempted while full.
REQ-017 Port o_udf, output, 1: sticky flag; read attempted while empty.

Function
REQ-018 Write accept: wr && !o_full; the entry is stored at the write pointer and wptr increments at the edge.
REQ-019 Read accept: rd && !o_empty; rptr increments at the edge and out shows the next entry in the following cycle.
REQ-020 Acceptance uses the pre-edge o_full/o_empty; a read never makes room for a same-cycle write.
REQ-021 Simultaneous accepted read and write: o_count unchanged; both pointers advance.
REQ-022 Full with wr&&rd: only the read is accepted, the write is dropped, and o_ovf sets.
REQ-023 Empty with wr&&rd: only the write is accepted, the read is ignored, and o_udf sets.
REQ-024 Write latency: data written at edge N appears on out after edge N when the FIFO was empty (0-cycle fall-through from storage).
REQ-025 out is undefined while o_empty=1 and shall not be checked then.
REQ-026 Pointers are clog2(depth) bits and wrap modulo depth; o_count is tracked as a separate counter.
REQ-027 o_full, o_empty, o_afull, and o_count are registered and all change on the same edge as the count.
REQ-028 Once set, o_ovf and o_udf hold until reset.
REQ-029 Lanes share pointers and flags; a given lane's data shall never appear in any other lane.

Reset
REQ-030 Reset at an edge sets wptr=0, rptr=0, o_count=0, o_empty=1, o_full=0, o_afull=0, o_ovf=0, o_udf=0.
REQ-031 Reset overrides wr and rd asserted in the same cycle; any occupancy is discarded mid-operation.
REQ-032 Storage contents are not reset.

Structure
REQ-033 Shared package fifo_pkg holds the default bw, width, and depth values plus a clog2 constant function for the count and pointer widths.
REQ-034 Sub-module fifo_ptr_ctrl holds the pointers, count, flags, and sticky errors; the top holds the width*bw x depth storage and read mux.

Verification
REQ-035 Config bw=4, width=2, depth=8, af_level=6: reset, write 0x11..0x88 -> o_count=8, o_full=1, o_afull from count 6, o_ready=0.
REQ-036 From full, wr=1 with in=0x99 -> o_ovf=1, o_count=8; then 8 reads -> out sequence 0x11..0x88 and o_empty=1.
REQ-037 Empty, wr&&rd with in=0x5A -> o_count=1, o_udf=1, out=0x5A next cycle.
REQ-038 Half full (4 entries), wr&&rd continuously for 20 cycles -> o_count stays 4, both pointers wrap, data order preserved.
REQ-039 At count 5, assert reset together with wr=1 -> next cycle o_count=0, o_empty=1, o_ovf=0, o_udf=0.
REQ-040 Write lane0=0xF, lane1=0x0 -> out[3:0]=0xF and out[7:4]=0x0, with no lane crossing.
